multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory-wait timeout and sticky halted/illegal/mem_fault status flags.
module multicycle_control_unit #(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] instruction,
  input  logic         mem_ready,
  output logic         pc_write,
  output logic         ir_write,
  output logic         branch,
  output logic         mem_read,
  output logic         mem_write,
  output logic         mem_to_reg,
  output logic         alu_src,
  output logic         reg_write,
  output logic [1:0]   alu_op,
  output logic [1:0]   save_method,
  output logic [1:0]   wb_sel,
  output logic         halted,
  output logic         illegal,
  output logic         mem_fault,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       halted_q, halted_d, illegal_q, illegal_d, fault_q, fault_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc;
  logic       is_jal, is_jalr, is_fence, is_sys, legal, wait_expired;
  logic       unused_ir;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign unused_ir = ^{instruction[N-1:15], instruction[11:7]};

  assign is_r     = (opcode == 7'b0110011);
  assign is_i     = (opcode == 7'b0010011);
  assign is_ld    = (opcode == 7'b0000011);
  assign is_st    = (opcode == 7'b0100011);
  assign is_br    = (opcode == 7'b1100011);
  assign is_lui   = (opcode == 7'b0110111);
  assign is_auipc = (opcode == 7'b0010111);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111);
  assign is_fence = (opcode == 7'b0001111);
  assign is_sys   = (opcode == 7'b1110011);

  // Stores only support byte/half/word widths; other funct3 values are illegal.
  assign legal = is_r | is_i | is_ld | (is_st && funct3 <= 3'd2) | is_br | is_lui
               | is_auipc | is_jal | is_jalr | is_fence;

  assign wait_expired = !mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    case (state_q)
      FETCH, MEM: begin
        if (mem_ready) begin
          if (state_q == FETCH)  state_d = DECODE;
          else                   state_d = is_ld ? WB : FETCH;
        end else if (wait_expired) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        if (is_sys) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (legal) begin
          state_d = EXEC;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        if (is_ld || is_st)         state_d = MEM;
        else if (is_br || is_fence) state_d = FETCH;
        else                        state_d = WB;
      end
      WB:   state_d = FETCH;
      HALT: state_d = HALT;
      default: begin
        state_d   = HALT;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  // Strobes are masked while rst is low so an aborted access never writes.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    wb_sel     = 2'b00;
    if (rst) begin
      case (state_q)
        FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        EXEC: begin
          if (is_r) begin
            alu_op = 2'b10;
          end else if (is_i) begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
          end else if (is_br) begin
            alu_op = 2'b01;
            branch = 1'b1;
          end else if (is_ld | is_st | is_lui | is_auipc | is_jal | is_jalr) begin
            alu_src = 1'b1;
          end
        end
        MEM: begin
          mem_read  = is_ld;
          mem_write = is_st;
        end
        WB: begin
          reg_write = 1'b1;
          if (is_ld) begin
            mem_to_reg = 1'b1;
            wb_sel     = 2'b01;
          end else if (is_jal || is_jalr) begin
            wb_sel   = 2'b10;
            pc_write = 1'b1;
          end else if (is_lui) begin
            wb_sel = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    save_method = 2'b00;
    if (is_st) begin
      case (funct3)
        3'b001:  save_method = 2'b01;
        3'b010:  save_method = 2'b10;
        default: save_method = 2'b00;
      endcase
    end
  end

  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign mem_fault = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table, directed
// corner sequences, and a randomized run against an instruction-schedule model.
module tb_multicycle_control_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
  logic [1:0]  alu_op, save_method, wb_sel;
  logic        halted, illegal, mem_fault;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(.N(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .reg_write(reg_write), .alu_op(alu_op), .save_method(save_method),
    .wb_sel(wb_sel), .halted(halted), .illegal(illegal), .mem_fault(mem_fault),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {pc_write, ir_write, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write};
  endfunction

  function automatic logic [19:0] all_out();
    return {strobes(), alu_op, save_method, wb_sel, halted, illegal, mem_fault, state};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- reference model ----------------
  typedef enum {C_R, C_I, C_LD, C_ST, C_BR, C_LUI, C_AUIPC, C_JAL, C_JALR,
                C_FENCE, C_SYS, C_ILL} cls_e;

  function automatic cls_e classify(input logic [31:0] ir);
    case (ir[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return (ir[14:12] <= 3'd2) ? C_ST : C_ILL;
      7'b1100011: return C_BR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0001111: return C_FENCE;
      7'b1110011: return C_SYS;
      default:    return C_ILL;
    endcase
  endfunction

  // Phase letters: F fetch, D decode, E execute, M memory, W writeback.
  function automatic string sched(input cls_e c);
    case (c)
      C_BR, C_FENCE: return "FDE";
      C_LD:          return "FDEMW";
      C_ST:          return "FDEM";
      C_SYS, C_ILL:  return "FD";
      default:       return "FDEW";
    endcase
  endfunction

  function automatic logic [1:0] sm_of(input logic [31:0] ir);
    if (ir[6:0] != 7'b0100011) return 2'b00;
    case (ir[14:12])
      3'd1:    return 2'b01;
      3'd2:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [19:0] model_out(input byte ch, input cls_e c, input logic [31:0] ir,
                                            input logic rdy, input logic h, input logic il,
                                            input logic fl, input logic rst_hi);
    logic pcw, irw, br, mr, mw, m2r, asrc, rw;
    logic [1:0] aop, wb;
    logic [2:0] st;
    {pcw, irw, br, mr, mw, m2r, asrc, rw} = '0;
    aop = 2'b00; wb = 2'b00;
    if (!rst_hi) return {8'h00, 2'b00, sm_of(ir), 2'b00, 3'b000, 3'd0};
    case (ch)
      "F": begin mr = 1'b1; irw = rdy; pcw = rdy; st = 3'd0; end
      "D": st = 3'd1;
      "E": begin
        st = 3'd2;
        case (c)
          C_R:     aop = 2'b10;
          C_I:     begin aop = 2'b10; asrc = 1'b1; end
          C_BR:    begin aop = 2'b01; br = 1'b1; end
          C_FENCE: ;
          default: asrc = 1'b1;
        endcase
      end
      "M": begin st = 3'd3; if (c == C_LD) mr = 1'b1; else mw = 1'b1; end
      "W": begin
        st = 3'd4; rw = 1'b1;
        if (c == C_LD) begin m2r = 1'b1; wb = 2'b01; end
        else if (c == C_JAL || c == C_JALR) begin wb = 2'b10; pcw = 1'b1; end
        else if (c == C_LUI) wb = 2'b11;
      end
      default: st = 3'd5;
    endcase
    return {pcw, irw, br, mr, mw, m2r, asrc, rw, aop, sm_of(ir), wb, h, il, fl, st};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 21);
    if (k >= 10 && k < 20) k = k - 10;
    case (k)
      0:  r[6:0] = 7'b0110011;
      1:  r[6:0] = 7'b0010011;
      2:  r[6:0] = 7'b0000011;
      3:  begin r[6:0] = 7'b0100011; r[14:12] = 3'($urandom_range(0, 3)); end
      4:  r[6:0] = 7'b1100011;
      5:  r[6:0] = 7'b0110111;
      6:  r[6:0] = 7'b0010111;
      7:  r[6:0] = 7'b1101111;
      8:  r[6:0] = 7'b1100111;
      9:  r[6:0] = 7'b0001111;
      20: r[6:0] = 7'b1110011;
      default: r[6:0] = 7'b1111111;
    endcase
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    int          cycles;
    logic [1:0]  wb;
    logic [1:0]  sm;
    logic        hlt;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic run_vec(input vec_t v);
    int cyc;
    logic [1:0] wb_seen;
    do_reset();
    instruction = v.instr;
    mem_ready   = 1'b1;
    cyc = 0;
    wb_seen = 2'b00;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (state == 3'd4) wb_seen = wb_sel;
      if (k > 0 && (state == 3'd0 || state == 3'd5)) break;
      cyc++;
      @(negedge clk);
    end
    check($sformatf("vec %h cycles", v.instr), 32'(cyc), 32'(v.cycles));
    check($sformatf("vec %h wb_sel", v.instr), 32'(wb_seen), 32'(v.wb));
    check($sformatf("vec %h save_method", v.instr), 32'(save_method), 32'(v.sm));
    check($sformatf("vec %h flags", v.instr), 32'({halted, illegal, mem_fault}),
          32'({v.hlt, v.ill, 1'b0}));
  endtask

  int    step, waits;
  logic  m_halt, m_hlt, m_ill, m_flt;
  cls_e  cls;
  string sc;
  byte   ch;
  int    mw_cnt, rw_cnt;

  initial begin
    vecs[0]  = '{32'h00B50533, 4, 2'b00, 2'b00, 1'b0, 1'b0};  // add
    vecs[1]  = '{32'h00150513, 4, 2'b00, 2'b00, 1'b0, 1'b0};  // addi
    vecs[2]  = '{32'h0000A503, 5, 2'b01, 2'b00, 1'b0, 1'b0};  // lw
    vecs[3]  = '{32'h00A0A023, 4, 2'b00, 2'b10, 1'b0, 1'b0};  // sw
    vecs[4]  = '{32'h00A08023, 4, 2'b00, 2'b00, 1'b0, 1'b0};  // sb
    vecs[5]  = '{32'h00A09023, 4, 2'b00, 2'b01, 1'b0, 1'b0};  // sh
    vecs[6]  = '{32'h00A0B023, 2, 2'b00, 2'b00, 1'b0, 1'b1};  // store funct3=011
    vecs[7]  = '{32'h00000063, 3, 2'b00, 2'b00, 1'b0, 1'b0};  // beq
    vecs[8]  = '{32'h000012B7, 4, 2'b11, 2'b00, 1'b0, 1'b0};  // lui
    vecs[9]  = '{32'h00001297, 4, 2'b00, 2'b00, 1'b0, 1'b0};  // auipc
    vecs[10] = '{32'h000000EF, 4, 2'b10, 2'b00, 1'b0, 1'b0};  // jal
    vecs[11] = '{32'h000080E7, 4, 2'b10, 2'b00, 1'b0, 1'b0};  // jalr
    vecs[12] = '{32'h0000000F, 3, 2'b00, 2'b00, 1'b0, 1'b0};  // fence
    vecs[13] = '{32'h00000073, 2, 2'b00, 2'b00, 1'b1, 1'b0};  // ecall
    vecs[14] = '{32'h0000007F, 2, 2'b00, 2'b00, 1'b0, 1'b1};  // bad opcode

    rst = 1'b0;
    mem_ready = 1'b1;
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset strobes", 32'(strobes()), 32'h0);
    check("reset flags", 32'({halted, illegal, mem_fault}), 32'h0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // ADD cycle-by-cycle: states 0,1,2,4,0
    do_reset();
    instruction = 32'h00B50533;
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("add state c%0d", k), 32'(state), (k == 0 || k == 4) ? 32'd0 :
            (k == 3) ? 32'd4 : 32'(k));
      if (k == 0) check("add fetch strobes", 32'({ir_write, pc_write}), 32'h3);
      if (k == 3) check("add wb", 32'({reg_write, wb_sel}), 32'h4);
      @(negedge clk);
    end

    // SW with three wait cycles in MEM
    do_reset();
    instruction = 32'h00A0A023;
    mw_cnt = 0; rw_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      mem_ready = (k < 3 || k == 6);
      #1;
      if (mem_write) mw_cnt++;
      if (reg_write) rw_cnt++;
      if (k == 4) check("sw save_method", 32'(save_method), 32'h2);
      @(negedge clk);
    end
    #1;
    check("sw mem_write cycles", 32'(mw_cnt), 32'd4);
    check("sw reg_write cycles", 32'(rw_cnt), 32'd0);
    check("sw next state", 32'(state), 32'd0);
    check("sw no fault", 32'(mem_fault), 32'd0);

    // Illegal opcode: HALT absorbs, strobes stay low
    do_reset();
    instruction = 32'h0000007F;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      mem_ready = k[0];
      #1;
      check($sformatf("halt c%0d", k), 32'({strobes(), illegal, state}), 32'({8'h00, 1'b1, 3'd5}));
      @(negedge clk);
    end

    // Timeout: stuck low faults after TO waits; ready on the last cycle completes
    do_reset();
    instruction = 32'h00B50533;
    mem_ready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      #1;
      check($sformatf("to wait c%0d", k), 32'({ir_write, pc_write, state}), 32'h0);
      @(negedge clk);
    end
    #1;
    check("timeout state", 32'(state), 32'd5);
    check("timeout flag", 32'(mem_fault), 32'd1);
    do_reset();
    for (int k = 0; k < TO; k++) begin
      mem_ready = (k == TO - 1);
      @(negedge clk);
    end
    #1;
    check("late ready state", 32'(state), 32'd1);
    check("late ready fault", 32'(mem_fault), 32'd0);

    // Reset during a store's MEM phase
    do_reset();
    instruction = 32'h00A0A023;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("mid-mem write", 32'({state, mem_write}), 32'({3'd3, 1'b1}));
    #1;
    rst = 1'b0;
    #1;
    check("reset abort", 32'({state, mem_write, mem_read}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("resume fetch", 32'({state, mem_read, halted, illegal, mem_fault}), 32'({3'd0, 1'b1, 3'b000}));
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("resume decode", 32'(state), 32'd1);

    // Randomized run against the schedule model
    step = 0; waits = 0; m_halt = 0; m_hlt = 0; m_ill = 0; m_flt = 0;
    @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      if (c == 0 || (m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0))) begin
        rst = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("rand reset", 32'(all_out()),
              32'(model_out("F", C_R, instruction, mem_ready, 1'b0, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        rst = 1'b1;
        step = 0; waits = 0; m_halt = 0; m_hlt = 0; m_ill = 0; m_flt = 0;
        continue;
      end
      if (!m_halt && step == 0 && waits == 0) instruction = rand_instr();
      mem_ready = ($urandom_range(0, 3) != 0);
      cls = classify(instruction);
      sc  = sched(cls);
      ch  = m_halt ? "H" : sc[step];
      #1;
      check($sformatf("rand c%0d ir %h", c, instruction), 32'(all_out()),
            32'(model_out(ch, cls, instruction, mem_ready, m_hlt, m_ill, m_flt, 1'b1)));
      if (!m_halt) begin
        if (ch == "F" || ch == "M") begin
          if (mem_ready) begin
            waits = 0;
            step = (step + 1 == sc.len()) ? 0 : step + 1;
          end else begin
            waits++;
            if (waits == TO) begin m_halt = 1; m_flt = 1; end
          end
        end else if (ch == "D" && (cls == C_SYS || cls == C_ILL)) begin
          m_halt = 1;
          if (cls == C_SYS) m_hlt = 1; else m_ill = 1;
        end else begin
          step = (step + 1 == sc.len()) ? 0 : step + 1;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
